ctrl_pipe_chain: RTL and testbench
==================================

Name: ctrl_pipe_chain

Overview:
- Parametrised carrier for decoded control and exception flags from ID through the later pipeline stages (default E, M, W).
- Generalises the hand-written ID→EX→MEM control registers to N stages of arbitrary width.
- Adds per-stage valid tracking, bubble insertion on upstream stall, suppression of side-effect bits for excepting instructions, and exception priority encoding at the last stage.
- Sits between main decode (ID-stage combinational signals) and datapath / CP0 logic.

Parameters:
CTRL_W, 16, width of the control bundle carried per stage
EXC_W, 4, number of exception flags (bit 0 highest priority, e.g. ri, break, syscall, eret)
STAGES, 3, number of register stages after ID (stage 0 = E, STAGES-1 = last)
SIDE_MASK, 16'h0000, CTRL_W-bit mask of side-effecting bits (reg/mem/hilo/cp0 write enables), forced to 0 for excepting instructions

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ctrl_d  in  CTRL_W  ID-stage control bundle
exc_d  in  EXC_W  ID-stage exception flags
valid_d  in  1  ID holds a real instruction
stall  in  STAGES  per-stage stall, bit k = stage k holds
flush  in  STAGES  per-stage flush, bit k = stage k loads bubble
ctrl_q  out  STAGES*CTRL_W  stage k bundle at bits [k*CTRL_W +: CTRL_W], side bits masked
exc_q  out  STAGES*EXC_W  stage k exception flags
valid_q  out  STAGES  per-stage valid
exc_last  out  1  last stage valid and any exception flag set
exc_idx_last  out  max(1,$clog2(EXC_W))  index of highest-priority (lowest) set flag in last stage; 0 when exc_last=0

Behaviour:
- Single clock domain. All state updates on posedge clk.
- Reset is synchronous and active-high: rst=1 clears every stage register (ctrl, exc, valid) to 0 on the next edge. Outputs are then all 0, including exc_last and exc_idx_last.
- Source of stage k: ID inputs for k=0; stage k-1 registers for k>0. Stage "-1" stall is the external ID hold, given by `stall[k-1]` for k>0. For k=0, the upstream-stall term is constant 0, because the ID stall is handled by the source.
- Per-stage update, highest priority first:
  1. rst → clear.
  2. flush[k] → bubble (ctrl=0, exc=0, valid=0). Flush beats stall.
  3. stall[k] → hold all fields.
  4. k>0 and stall[k-1]=1 → bubble. This prevents duplicating a held instruction.
  5. Otherwise → load from source.
- Valid gating on load: if the source valid is 0, stored ctrl and exc are forced to 0.
- Output masking is combinational: ctrl_q slice = stored ctrl & ~(SIDE_MASK & {CTRL_W{|exc_stored}}). Stored ctrl stays raw; only the output is masked.
- Latency: an ID value appears at stage k outputs k+1 cycles later with no stalls.
- exc_last / exc_idx_last: combinational from the last-stage registers. Priority encoder selects the lowest set index.
- Boundaries:
  - STAGES=1: rule 4 never applies.
  - EXC_W=1: exc_idx_last is 1 bit, always 0.
  - Simultaneous flush and stall on the same stage: bubble.
  - rst mid-stall: cleared regardless.
- No combinational path from stall/flush to outputs. Outputs depend only on registers.

Optional Feature:
- Macro: CTRL_PIPE_PERF_EN.
- Defined:
  - Adds output `bubble_cnt` [31:0].
  - Increments by 1 each cycle the last stage loads a bubble via rule 2, rule 4, or invalid-source load.
  - Saturates at 32'hFFFF_FFFF. Cleared by rst.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Flow, no stalls (CTRL_W=8, STAGES=3): valid_d=1, ctrl_d=8'hA5 at cycle 0 → ctrl_q stage0=A5 at cycle 1, stage1 at cycle 2, stage2 at cycle 3; valid_q follows 001→010→100.
- Stall bubble: hold stall[0]=1 for 2 cycles with A5 in stage 0 → stage0 keeps A5. Stage1 shows valid=0, ctrl=0 for 2 cycles, then A5 appears once stall drops. Exactly one A5 reaches stage 2.
- Flush beats stall: stall[1]=1 and flush[1]=1 in the same cycle with 8'h3C in stage 1 → next cycle stage1 valid=0, ctrl=0.
- Exception masking (SIDE_MASK=8'h0F): ctrl_d=8'hFF, exc_d=4'b0110 → stage outputs 8'hF0. At stage 2: exc_last=1, exc_idx_last=1. The stored value reappears unmasked if exc were 0 (check with exc_d=0 → 8'hFF).
- Reset mid-operation: pipeline full of valid entries, rst=1 for one cycle with stall=3'b111 → all valid_q=0, ctrl_q=0, exc_last=0 after the edge.
- With CTRL_PIPE_PERF_EN: 5 cycles valid_d=0 after reset → bubble_cnt=5 at cycle 5 (minus fill latency alignment noted by bench). Force counter to FFFF_FFFF → stays saturated.

Source files
------------

// File: rtl/ctrl_pipe_chain.sv
// ctrl_pipe_chain: N-stage control/exception carrier with bubbles, side-effect masking and last-stage exception priority; CTRL_PIPE_PERF_EN adds bubble_cnt
module ctrl_pipe_chain #(
  parameter int CTRL_W = 16,
  parameter int EXC_W = 4,
  parameter int STAGES = 3,
  parameter logic [CTRL_W-1:0] SIDE_MASK = '0
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [CTRL_W-1:0]                         ctrl_d,
  input  logic [EXC_W-1:0]                          exc_d,
  input  logic                                      valid_d,
  input  logic [STAGES-1:0]                         stall,
  input  logic [STAGES-1:0]                         flush,
  output logic [STAGES*CTRL_W-1:0]                  ctrl_q,
  output logic [STAGES*EXC_W-1:0]                   exc_q,
  output logic [STAGES-1:0]                         valid_q,
  output logic                                      exc_last,
  output logic [(EXC_W > 1 ? $clog2(EXC_W) : 1)-1:0] exc_idx_last
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [31:0]                               bubble_cnt
`endif
);
  localparam int IDX_W = EXC_W > 1 ? $clog2(EXC_W) : 1;
  localparam int L = STAGES - 1;
  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_stage
    logic [CTRL_W-1:0] c_q, c_d, src_ctrl;
    logic [EXC_W-1:0] e_q, e_d, src_exc;
    logic v_q, v_d, src_valid, up_stall, bub;
    if (k == 0) begin : g_id
      assign src_ctrl = ctrl_d;
      assign src_exc = exc_d;
      assign src_valid = valid_d;
      assign up_stall = 1'b0;
    end else begin : g_prev
      assign src_ctrl = g_stage[k-1].c_q;
      assign src_exc = g_stage[k-1].e_q;
      assign src_valid = g_stage[k-1].v_q;
      assign up_stall = stall[k-1];
    end
    assign bub = flush[k] | (~stall[k] & up_stall);
    // flush or held upstream gives a bubble, stall holds, otherwise load with invalid entries zeroed
    always_comb begin
      v_d = bub ? 1'b0 : stall[k] ? v_q : src_valid;
      c_d = bub ? '0 : stall[k] ? c_q : src_valid ? src_ctrl : '0;
      e_d = bub ? '0 : stall[k] ? e_q : src_valid ? src_exc : '0;
    end
    // stage register
    always_ff @(posedge clk) begin
      if (rst) begin
        c_q <= '0;
        e_q <= '0;
        v_q <= 1'b0;
      end else begin
        c_q <= c_d;
        e_q <= e_d;
        v_q <= v_d;
      end
    end
    assign ctrl_q[k*CTRL_W +: CTRL_W] = c_q & ~(SIDE_MASK & {CTRL_W{|e_q}});
    assign exc_q[k*EXC_W +: EXC_W] = e_q;
    assign valid_q[k] = v_q;
  end
  logic [EXC_W-1:0] last_exc;
  assign last_exc = g_stage[L].e_q;
  assign exc_last = g_stage[L].v_q & |last_exc;
  // lowest set flag wins; scanning downward leaves the lowest index last
  always_comb begin
    exc_idx_last = '0;
    for (int i = EXC_W - 1; i >= 0; i--)
      if (exc_last && last_exc[i]) exc_idx_last = IDX_W'(i);
  end
`ifdef CTRL_PIPE_PERF_EN
  logic [31:0] bubble_cnt_q;
  logic last_bub;
  assign last_bub = g_stage[L].bub | (~stall[L] & ~g_stage[L].src_valid);
  // saturating count of bubbles entering the last stage
  always_ff @(posedge clk) begin
    bubble_cnt_q <= rst ? '0 : (last_bub && ~&bubble_cnt_q) ? bubble_cnt_q + 32'd1 : bubble_cnt_q;
  end
  assign bubble_cnt = bubble_cnt_q;
`endif
endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// tb_ctrl_pipe_chain: directed bench with last-stage scoreboard for ctrl_pipe_chain
module tb_ctrl_pipe_chain;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] ctrl_d = '0;
  logic [3:0] exc_d = '0;
  logic valid_d = 1'b0;
  logic [2:0] stall = '0, flush = '0;
  logic [23:0] ctrl_q;
  logic [11:0] exc_q;
  logic [2:0] valid_q;
  logic exc_last;
  logic [1:0] exc_idx_last;
`ifdef CTRL_PIPE_PERF_EN
  logic [31:0] bubble_cnt;
`endif
  typedef struct {logic [7:0] c; logic el; logic [1:0] idx;} exp_t;
  exp_t sb[$];
  int passed = 0, total = 0, fails = 0;

  ctrl_pipe_chain #(.CTRL_W(8), .EXC_W(4), .STAGES(3), .SIDE_MASK(8'h0F)) dut (
    .clk(clk), .rst(rst), .ctrl_d(ctrl_d), .exc_d(exc_d), .valid_d(valid_d),
    .stall(stall), .flush(flush), .ctrl_q(ctrl_q), .exc_q(exc_q), .valid_q(valid_q),
    .exc_last(exc_last), .exc_idx_last(exc_idx_last)
`ifdef CTRL_PIPE_PERF_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] cs(input int k);
    return ctrl_q[k*8 +: 8];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] c, input logic [3:0] e);
    valid_d = v;
    ctrl_d = c;
    exc_d = e;
  endtask

  // every valid last-stage entry must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (valid_q[2]) begin
      chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t x;
        x = sb.pop_front();
        chk("sb_ctrl2", 32'(cs(2)), 32'(x.c));
        chk("sb_exc_last", 32'(exc_last), 32'(x.el));
        chk("sb_exc_idx", 32'(exc_idx_last), 32'(x.idx));
      end
    end
  end

  logic [7:0] tc[4] = '{8'hFF, 8'hFF, 8'h5A, 8'h3C};
  logic [3:0] te[4] = '{4'b0110, 4'b0000, 4'b1000, 4'b1001};
  logic [7:0] tm[4] = '{8'hF0, 8'hFF, 8'h50, 8'h30};
  logic [1:0] ti[4] = '{2'd1, 2'd0, 2'd3, 2'd0};

  initial begin
    tick;
    tick;
    chk("rst_valid", 32'(valid_q), 32'd0);
    chk("rst_ctrl", 32'(ctrl_q), 32'd0);
    chk("rst_exc", 32'(exc_q), 32'd0);
    chk("rst_exc_last", 32'(exc_last), 32'd0);
    chk("rst_idx", 32'(exc_idx_last), 32'd0);
    rst = 1'b0;
    // plain flow
    drive(1'b1, 8'hA5, 4'h0);
    sb.push_back('{8'hA5, 1'b0, 2'd0});
    tick;
    drive(1'b0, 8'h00, 4'h0);
    chk("flow_c0", 32'(cs(0)), 32'hA5);
    chk("flow_v1", 32'(valid_q), 32'b001);
    tick;
    chk("flow_c1", 32'(cs(1)), 32'hA5);
    chk("flow_v2", 32'(valid_q), 32'b010);
    tick;
    chk("flow_c2", 32'(cs(2)), 32'hA5);
    chk("flow_v3", 32'(valid_q), 32'b100);
    tick;
    chk("flow_v4", 32'(valid_q), 32'b000);
    // stall on stage 0 inserts bubbles into stage 1
    drive(1'b1, 8'hA5, 4'h0);
    sb.push_back('{8'hA5, 1'b0, 2'd0});
    tick;
    drive(1'b0, 8'h00, 4'h0);
    stall = 3'b001;
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("stall_c0", 32'(cs(0)), 32'hA5);
      chk("stall_v", 32'(valid_q), 32'b001);
      chk("stall_c1", 32'(cs(1)), 32'h00);
    end
    stall = 3'b000;
    tick;
    chk("stall_rel_c1", 32'(cs(1)), 32'hA5);
    chk("stall_rel_v", 32'(valid_q), 32'b010);
    tick;
    tick;
    chk("stall_drain_v", 32'(valid_q), 32'b000);
    // flush beats stall
    drive(1'b1, 8'h3C, 4'h0);
    tick;
    drive(1'b0, 8'h00, 4'h0);
    tick;
    chk("fl_pre_c1", 32'(cs(1)), 32'h3C);
    stall = 3'b010;
    flush = 3'b010;
    tick;
    stall = 3'b000;
    flush = 3'b000;
    chk("fl_v", 32'(valid_q), 32'b000);
    chk("fl_c1", 32'(cs(1)), 32'h00);
    // side-effect masking and exception priority
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, tc[i], te[i]);
      sb.push_back('{tm[i], te[i] != 4'h0, ti[i]});
      tick;
      chk("mask_c0", 32'(cs(0)), 32'(tm[i]));
      chk("mask_e0", 32'(exc_q[3:0]), 32'(te[i]));
    end
    drive(1'b0, 8'h00, 4'h0);
    repeat (4) tick;
    // reset while stalled with a full pipe
    drive(1'b1, 8'h11, 4'h0);
    sb.push_back('{8'h11, 1'b0, 2'd0});
    tick;
    drive(1'b1, 8'h22, 4'h0);
    tick;
    drive(1'b1, 8'h33, 4'h0);
    tick;
    chk("full_v", 32'(valid_q), 32'b111);
    rst = 1'b1;
    stall = 3'b111;
    drive(1'b1, 8'h44, 4'h2);
    tick;
    chk("mid_rst_v", 32'(valid_q), 32'd0);
    chk("mid_rst_c", 32'(ctrl_q), 32'd0);
    chk("mid_rst_el", 32'(exc_last), 32'd0);
    rst = 1'b0;
    stall = 3'b000;
    drive(1'b0, 8'h00, 4'h0);
`ifdef CTRL_PIPE_PERF_EN
    chk("perf_rst", bubble_cnt, 32'd0);
    repeat (5) tick;
    chk("perf_5", bubble_cnt, 32'd5);
    force dut.bubble_cnt_q = 32'hFFFF_FFFF;
    tick;
    release dut.bubble_cnt_q;
    tick;
    tick;
    chk("perf_sat", bubble_cnt, 32'hFFFF_FFFF);
`endif
    tick;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
